// File: rtl/collision_event_arbiter_if.sv
// Event handshake between the collision arbiter (master) and the ball physics block (slave).
interface collision_event_arbiter_if;
    logic       eventValid;
    logic       eventReady;
    logic [2:0] eventId;
    logic [1:0] eventFactor;

    modport master (output eventValid, output eventId, output eventFactor, input eventReady);
    modport slave  (input eventValid, input eventId, input eventFactor, output eventReady);
endinterface

// File: rtl/collision_event_arbiter.sv
// Resolves per-pixel collision flags into at most one prioritised event per video frame.
// Define COLLISION_ARB_STATS_EN to compile in the saturating droppedCount statistic.
module collision_event_arbiter #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     pause,
    input  logic                     collisionBallFlipper,
    input  logic                     collisionBallBumper,
    input  logic                     collisionBallObstacle,
    input  logic                     collisionBallSpringPulse,
    input  logic                     collisionBallFrame,
    input  logic [1:0]               collisionFactor,
    collision_event_arbiter_if.master evt,
    output logic [7:0]               droppedCount
);

    typedef enum logic [1:0] {IDLE, ARB, OFFER} state_t;

    state_t           state, state_next;
    logic [4:0]       hits, live, sticky, pending;
    logic [1:0]       factor_sticky, pend_factor;
    logic [CNT_W-1:0] cooldown [5];
    logic [2:0]       winner;
    logic             snap, stall, arb_fire, accept;

    // A source may only mark the window while it is out of cooldown and the game runs.
    always_comb begin
        hits = {collisionBallFrame, collisionBallSpringPulse, collisionBallObstacle,
                collisionBallBumper, collisionBallFlipper};
        for (int i = 0; i < 5; i++)
            live[i] = hits[i] && (cooldown[i] == '0) && !pause;
    end

    always_comb begin
        winner = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (pending[i]) winner = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        snap       = 1'b0;
        stall      = 1'b0;
        arb_fire   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (startOfFrame && !pause) begin
                    snap       = 1'b1;
                    state_next = ARB;
                end
            end
            ARB: begin
                if (pending == '0) begin
                    state_next = IDLE;
                end else begin
                    arb_fire   = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (evt.eventReady) begin
                    accept = 1'b1;
                    if (startOfFrame && !pause) begin
                        snap       = 1'b1;
                        state_next = ARB;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (startOfFrame && !pause) begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Collisions in a frame-start cycle belong to the freshly cleared window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky          <= '0;
            factor_sticky   <= '0;
            pending         <= '0;
            pend_factor     <= '0;
            for (int i = 0; i < 5; i++) cooldown[i] <= '0;
            evt.eventValid  <= 1'b0;
            evt.eventId     <= '0;
            evt.eventFactor <= '0;
        end else begin
            if (snap || stall) begin
                sticky        <= live;
                factor_sticky <= live[1] ? collisionFactor : 2'd0;
            end else begin
                sticky <= sticky | live;
                if (live[1] && !sticky[1]) factor_sticky <= collisionFactor;
            end
            if (snap) begin
                pending     <= sticky;
                pend_factor <= factor_sticky;
            end
            for (int i = 0; i < 5; i++) begin
                if (arb_fire && winner == 3'(i))
                    cooldown[i] <= CNT_W'(COOLDOWN_FRAMES);
                else if ((snap || stall) && cooldown[i] != '0)
                    cooldown[i] <= cooldown[i] - CNT_W'(1);
            end
            if (arb_fire) begin
                evt.eventValid  <= 1'b1;
                evt.eventId     <= winner;
                evt.eventFactor <= (winner == 3'd1) ? pend_factor : 2'd0;
            end else if (accept) begin
                evt.eventValid  <= 1'b0;
            end
        end
    end

`ifdef COLLISION_ARB_STATS_EN
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Losers of an arbitration, and whole windows lost to a stalled consumer, are counted.
    always_ff @(posedge clk) begin
        if (reset)         droppedCount <= '0;
        else if (arb_fire) droppedCount <= sat_add(droppedCount, popcount5(pending) - 3'd1);
        else if (stall)    droppedCount <= sat_add(droppedCount, popcount5(sticky));
    end
`else
    assign droppedCount = '0;
`endif

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Bench for collision_event_arbiter: directed scenarios then randomized frames vs. a frame-level model.
module tb_collision_event_arbiter;
    localparam int CF = 4;
`ifdef COLLISION_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, sof, pause;
    logic [4:0] col;
    logic [1:0] cfac;
    logic [7:0] dropped;

    collision_event_arbiter_if evt_if();

    collision_event_arbiter #(.COOLDOWN_FRAMES(CF), .CNT_W(3)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .startOfFrame             (sof),
        .pause                    (pause),
        .collisionBallFlipper     (col[0]),
        .collisionBallBumper      (col[1]),
        .collisionBallObstacle    (col[2]),
        .collisionBallSpringPulse (col[3]),
        .collisionBallFrame       (col[4]),
        .collisionFactor          (cfac),
        .evt                      (evt_if),
        .droppedCount             (dropped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one window of hits, one snapshot, one offered event, per-source frame cooldowns.
    int m_cd [5];
    bit m_sticky [5];
    bit m_pend [5];
    int m_fs, m_pf, m_id, m_fac, m_drop;
    bit m_valid, m_arb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat255(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic model_edge(input bit rs, input bit s, input logic [4:0] c, input logic [1:0] f,
                              input bit r, input bit p);
        bit hitok [5];
        bit take, clr;
        int cnt, w;
        if (rs) begin
            for (int i = 0; i < 5; i++) begin m_cd[i] = 0; m_sticky[i] = 0; m_pend[i] = 0; end
            m_fs = 0; m_pf = 0; m_id = 0; m_fac = 0; m_drop = 0; m_valid = 0; m_arb = 0;
            return;
        end
        for (int i = 0; i < 5; i++) hitok[i] = c[i] && (m_cd[i] == 0) && !p;
        take = 0; clr = 0;
        if (m_arb) begin
            m_arb = 0; cnt = 0; w = -1;
            for (int i = 4; i >= 0; i--) if (m_pend[i]) begin cnt++; w = i; end
            if (cnt > 0) begin
                m_valid = 1; m_id = w; m_fac = (w == 1) ? m_pf : 0;
                m_cd[w] = CF; m_drop = sat255(m_drop + cnt - 1);
            end
        end else if (m_valid && r) begin
            m_valid = 0; take = s && !p;
        end else if (m_valid) begin
            if (s && !p) begin
                cnt = 0;
                for (int i = 0; i < 5; i++) cnt += m_sticky[i];
                m_drop = sat255(m_drop + cnt); clr = 1;
            end
        end else begin
            take = s && !p;
        end
        if (take) begin m_pend = m_sticky; m_pf = m_fs; clr = 1; m_arb = 1; end
        if (clr) begin
            for (int i = 0; i < 5; i++) begin
                if (m_cd[i] > 0) m_cd[i]--;
                m_sticky[i] = 0;
            end
            m_fs = 0;
        end
        for (int i = 0; i < 5; i++)
            if (hitok[i]) begin
                if (i == 1 && !m_sticky[1]) m_fs = f;
                m_sticky[i] = 1;
            end
    endtask

    task automatic step(input bit rs, input bit s, input logic [4:0] c, input logic [1:0] f,
                        input bit r, input bit p);
        reset = rs; sof = s; col = c; cfac = f; evt_if.eventReady = r; pause = p;
        model_edge(rs, s, c, f, r, p);
        @(posedge clk); #1;
        check("valid", evt_if.eventValid, m_valid);
        if (m_valid) begin
            check("id", evt_if.eventId, m_id);
            check("factor", evt_if.eventFactor, m_fac);
        end
        check("dropped", dropped, STATS ? m_drop : 0);
    endtask

    task automatic quiet(input int n, input bit r);
        repeat (n) step(0, 0, 5'b0, 2'd0, r, 0);
    endtask
    task automatic hit(input logic [4:0] c, input logic [1:0] f, input bit r);
        step(0, 0, c, f, r, 0);
    endtask
    task automatic frame_start(input bit r);
        step(0, 1, 5'b0, 2'd0, r, 0);
    endtask

    initial begin
        int d0, len;
        bit r, p;
        logic [4:0] c;
        reset = 1; sof = 0; pause = 0; col = '0; cfac = '0; evt_if.eventReady = 0;

        // Reset state
        step(1, 0, 5'b0, 2'd0, 0, 0);
        step(1, 0, 5'b0, 2'd0, 0, 0);
        check("rst_valid", evt_if.eventValid, 0);
        check("rst_id", evt_if.eventId, 0);
        check("rst_factor", evt_if.eventFactor, 0);
        check("rst_drop", dropped, 0);

        // Frame-only hit, ready tied high: one-cycle event two edges after the frame start
        quiet(3, 1); hit(5'b10000, 0, 1); quiet(2, 1);
        frame_start(1);
        check("t1_arb_valid", evt_if.eventValid, 0);
        quiet(1, 1);
        check("t1_valid", evt_if.eventValid, 1);
        check("t1_id", evt_if.eventId, 4);
        check("t1_drop", dropped, 0);
        quiet(1, 1);
        check("t1_pulse_end", evt_if.eventValid, 0);

        // Flipper beats frame, then flipper is blocked for four frame starts
        hit(5'b00001, 0, 1); hit(5'b10000, 0, 1); quiet(1, 1);
        frame_start(1); quiet(1, 1);
        check("t2_id", evt_if.eventId, 0);
        check("t2_drop", dropped, STATS ? 1 : 0);
        quiet(1, 1);
        for (int k = 0; k < 4; k++) begin
            quiet(2, 1); hit(5'b00001, 0, 1); quiet(2, 1);
            frame_start(1); quiet(2, 1);
            check("t2_blocked", evt_if.eventValid, 0);
        end
        quiet(2, 1); hit(5'b00001, 0, 1); quiet(2, 1);
        frame_start(1); quiet(1, 1);
        check("t2_rearm_valid", evt_if.eventValid, 1);
        check("t2_rearm_id", evt_if.eventId, 0);
        quiet(1, 1);

        // Bumper factor latched from the first bumper pixel of the window
        hit(5'b00010, 2, 1); quiet(1, 1); hit(5'b00010, 3, 1);
        frame_start(1); quiet(1, 1);
        check("t3_id", evt_if.eventId, 1);
        check("t3_factor", evt_if.eventFactor, 2);
        quiet(1, 1);

        // Consumer stalls across two frame starts; second window has two hits
        hit(5'b00100, 0, 0); frame_start(0); quiet(1, 0);
        check("t4_valid", evt_if.eventValid, 1);
        quiet(2, 0); frame_start(0); quiet(1, 0);
        hit(5'b01000, 0, 0); hit(5'b10000, 0, 0);
        d0 = m_drop;
        frame_start(0);
        check("t4_hold_valid", evt_if.eventValid, 1);
        check("t4_hold_id", evt_if.eventId, 2);
        check("t4_drop", dropped, STATS ? d0 + 2 : 0);
        quiet(2, 1);

        // Paused frame: hit and frame start both ignored, next frame has nothing to report
        step(0, 0, 5'b01000, 0, 1, 1);
        step(0, 1, 5'b00000, 0, 1, 1);
        quiet(2, 1);
        check("t5_paused", evt_if.eventValid, 0);
        quiet(3, 1); frame_start(1); quiet(2, 1);
        check("t5_empty", evt_if.eventValid, 0);

        // Reset during an offer, then a normal frame
        hit(5'b10000, 0, 0); frame_start(0); quiet(1, 0);
        check("t6_offer", evt_if.eventValid, 1);
        step(1, 0, 5'b0, 2'd0, 0, 0);
        check("t6_rst_valid", evt_if.eventValid, 0);
        check("t6_rst_drop", dropped, 0);
        hit(5'b10000, 0, 1); frame_start(1); quiet(1, 1);
        check("t6_new_valid", evt_if.eventValid, 1);
        check("t6_new_id", evt_if.eventId, 4);
        quiet(1, 1);

        // Randomized frames against the model
        for (int fr = 0; fr < 300; fr++) begin
            len = $urandom_range(4, 12);
            p = ($urandom_range(0, 9) == 0);
            for (int cy = 0; cy < len; cy++) begin
                c = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
                r = ($urandom_range(0, 9) < 7);
                step(($urandom_range(0, 299) == 0), 0, c, 2'($urandom), r, p);
            end
            r = ($urandom_range(0, 9) < 7);
            step(0, 1, 5'($urandom) & 5'($urandom), 2'($urandom), r, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
